// File: rtl/hnf_rxreq.sv
// HNF RXREQ link receiver: issues CHI link credits, checks target ID and buffers
// accepted request flits in the POCQ, presenting the oldest entry show-ahead.

package hnf_rxreq_pkg;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgtid;
    logic [6:0]  srcid;
    logic [7:0]  txnid;
    logic [5:0]  opcode;
    logic [47:0] addr;
  } reqflit_t;

  localparam logic [5:0] OPC_LCRD_RETURN = 6'h00;

endpackage

module hnf_rxreq
  import hnf_rxreq_pkg::*;
#(
  parameter int         DEPTH = 8,
  parameter logic [6:0] HN_ID = 7'd0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rxreqflitpend,
  input  logic                       rxreqflitv,
  input  reqflit_t                   rxreqflit,
  output logic                       rxreqlcrdv,
  input  logic                       link_up,
  output logic                       link_idle,
  output reqflit_t                   pocq_head,
  output logic                       pocq_head_v,
  input  logic                       pocq_pop,
  output logic [$clog2(DEPTH+1)-1:0] pocq_count,
  output logic                       err_tgtid,
  output logic                       err_crd
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         crd_q, crd_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               err_tgtid_q, err_tgtid_d;
  logic               err_crd_q, err_crd_d;
  reqflit_t           mem_q [DEPTH];

  logic               flit_ok;
  logic               enq;
  logic               deq;
  logic [4:0]         crd_sum;

  // The early-pend hint carries no information the receiver needs.
  logic unused_flitpend;
  assign unused_flitpend = rxreqflitpend;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) ptr_inc = '0;
    else                        ptr_inc = p + PTR_W'(1);
  endfunction

  assign flit_ok = rxreqflitv && (crd_q != 4'd0);
  assign enq     = flit_ok && (rxreqflit.opcode != OPC_LCRD_RETURN);
  assign deq     = pocq_pop && (count_q != '0);
  assign crd_sum = {1'b0, crd_q} + 5'(count_q);

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_STOP;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOP:  if (link_up) state_d = ST_RUN;
      ST_RUN:   if (!link_up) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (link_up)               state_d = ST_RUN;
        else if (crd_q == 4'd0)    state_d = ST_STOP;
      end
      default:  state_d = ST_STOP;
    endcase
  end

  // FSM: outputs; grants come only from registered state so they never chase
  // an arriving flit combinationally.
  always_comb begin
    rxreqlcrdv = 1'b0;
    link_idle  = 1'b0;
    unique case (state_q)
      ST_STOP:  link_idle  = 1'b1;
      ST_RUN:   rxreqlcrdv = (crd_sum < 5'(DEPTH));
      ST_DRAIN: rxreqlcrdv = 1'b0;
      default:  link_idle  = 1'b1;
    endcase
  end

  always_comb begin
    crd_d       = crd_q + 4'(rxreqlcrdv) - 4'(flit_ok);
    count_d     = count_q + CNT_W'(enq) - CNT_W'(deq);
    wr_ptr_d    = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    err_tgtid_d = enq && (rxreqflit.tgtid != HN_ID);
    err_crd_d   = rxreqflitv && (crd_q == 4'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      crd_q       <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_tgtid_q <= 1'b0;
      err_crd_q   <= 1'b0;
    end else begin
      crd_q       <= crd_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_tgtid_q <= err_tgtid_d;
      err_crd_q   <= err_crd_d;
    end
  end

  // Storage needs no reset: head validity is governed by count_q.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= rxreqflit;
  end

  assign pocq_head   = mem_q[rd_ptr_q];
  assign pocq_head_v = (count_q != '0);
  assign pocq_count  = count_q;
  assign err_tgtid   = err_tgtid_q;
  assign err_crd     = err_crd_q;

endmodule

// File: tb/tb_hnf_rxreq.sv
// Bench for hnf_rxreq: fixed vector table, scripted corner sequence and a
// randomized run against a queue-based reference model.

module tb_hnf_rxreq;
  import hnf_rxreq_pkg::*;

  localparam int         DEPTH = 4;
  localparam logic [6:0] HN    = 7'h05;
  localparam int         CW    = $clog2(DEPTH + 1);

  logic          clock;
  logic          reset;
  logic          rxreqflitpend;
  logic          rxreqflitv;
  reqflit_t      rxreqflit;
  logic          rxreqlcrdv;
  logic          link_up;
  logic          link_idle;
  reqflit_t      pocq_head;
  logic          pocq_head_v;
  logic          pocq_pop;
  logic [CW-1:0] pocq_count;
  logic          err_tgtid;
  logic          err_crd;

  hnf_rxreq #(.DEPTH(DEPTH), .HN_ID(HN)) dut (
    .clock         (clock),
    .reset         (reset),
    .rxreqflitpend (rxreqflitpend),
    .rxreqflitv    (rxreqflitv),
    .rxreqflit     (rxreqflit),
    .rxreqlcrdv    (rxreqlcrdv),
    .link_up       (link_up),
    .link_idle     (link_idle),
    .pocq_head     (pocq_head),
    .pocq_head_v   (pocq_head_v),
    .pocq_pop      (pocq_pop),
    .pocq_count    (pocq_count),
    .err_tgtid     (err_tgtid),
    .err_crd       (err_crd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic reqflit_t mk_flit(input int op, input int tg, input int tx);
    reqflit_t f;
    f.qos    = 4'h3;
    f.tgtid  = 7'(tg);
    f.srcid  = 7'h11;
    f.txnid  = 8'(tx);
    f.opcode = 6'(op);
    f.addr   = 48'h4000 + 48'(tx);
    return f;
  endfunction

  task automatic drive(input bit rst, input bit lu, input bit fv, input reqflit_t f, input bit pop);
    reset         = rst;
    link_up       = lu;
    rxreqflitv    = fv;
    rxreqflit     = f;
    pocq_pop      = pop;
    rxreqflitpend = fv;
  endtask

  // ---------------- fixed vector table ----------------
  typedef struct {
    bit rst; bit lu; bit fv; int op; int tg; int tx; bit pop;
    bit e_lcrdv; bit e_idle; bit e_hv; int e_cnt; bit e_et; bit e_ec; int e_tx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit rst, lu, fv, input int op, tg, tx, input bit pop,
                              input bit lc, idle, hv, input int cnt, input bit et, ec, input int etx);
    vec_t v;
    v = '{rst, lu, fv, op, tg, tx, pop, lc, idle, hv, cnt, et, ec, etx};
    return v;
  endfunction

  // ---------------- reference model ----------------
  int       m_state;   // 0 stop, 1 run, 2 drain
  int       m_crd;
  reqflit_t m_q[$];
  bit       m_et, m_ec;

  function automatic bit m_lcrdv();
    return (m_state == 1) && (m_crd + m_q.size() < DEPTH);
  endfunction

  task automatic m_update();
    bit g, acc;
    g   = m_lcrdv();
    acc = rxreqflitv && (m_crd > 0);
    if (reset) begin
      m_state = 0; m_crd = 0; m_q.delete(); m_et = 0; m_ec = 0;
    end else begin
      m_ec = rxreqflitv && (m_crd == 0);
      m_et = acc && (rxreqflit.opcode != 0) && (rxreqflit.tgtid != HN);
      if (pocq_pop && m_q.size() > 0) void'(m_q.pop_front());
      if (acc && rxreqflit.opcode != 0) m_q.push_back(rxreqflit);
      case (m_state)
        0: if (link_up) m_state = 1;
        1: if (!link_up) m_state = 2;
        default: if (link_up) m_state = 1; else if (m_crd == 0) m_state = 0;
      endcase
      m_crd = m_crd + int'(g) - int'(acc);
    end
  endtask

  task automatic step_model(input string tag);
    m_update();
    @(posedge clock); #1;
    chk({tag, " lcrdv"}, rxreqlcrdv, m_lcrdv());
    chk({tag, " idle"}, link_idle, m_state == 0);
    chk({tag, " head_v"}, pocq_head_v, m_q.size() > 0);
    chk({tag, " count"}, pocq_count, m_q.size());
    chk({tag, " err_tgtid"}, err_tgtid, m_et);
    chk({tag, " err_crd"}, err_crd, m_ec);
    if (m_q.size() > 0) chk({tag, " head"}, pocq_head, m_q[0]);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, mk_flit(1, HN, 0), 1'b0);

    //          rst lu fv op tg  tx  pop | lc idle hv cnt et ec etx
    tbl.push_back(mk(1, 0, 0, 0, 5,  0, 0,  0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 5,  1, 0,  0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 5,  2, 0,  0, 0, 1, 2, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 5,  3, 0,  0, 0, 1, 3, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  0, 0, 1, 3, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 1,  1, 0, 1, 2, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 1,  1, 0, 1, 1, 0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 1,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 6,  4, 0,  0, 0, 1, 1, 1, 0, 4));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  0, 0, 1, 1, 0, 0, 4));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 1,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 5,  5, 0,  0, 0, 1, 1, 0, 0, 5));
    tbl.push_back(mk(0, 1, 1, 1, 5,  6, 0,  0, 0, 1, 2, 0, 0, 5));
    tbl.push_back(mk(0, 1, 1, 1, 5,  7, 0,  0, 0, 1, 3, 0, 0, 5));
    tbl.push_back(mk(0, 1, 1, 1, 5,  8, 0,  0, 0, 1, 4, 0, 0, 5));
    tbl.push_back(mk(0, 1, 1, 1, 5,  9, 0,  0, 0, 1, 4, 0, 1, 5));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  0, 0, 1, 4, 0, 0, 5));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 1,  1, 0, 1, 3, 0, 0, 6));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 1,  1, 0, 1, 2, 0, 0, 7));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 1,  1, 0, 1, 1, 0, 0, 8));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 1,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 5, 10, 0,  0, 0, 1, 1, 0, 0, 10));
    tbl.push_back(mk(0, 1, 1, 1, 5, 11, 0,  0, 0, 1, 2, 0, 0, 10));
    tbl.push_back(mk(0, 0, 0, 0, 5,  0, 0,  0, 0, 1, 2, 0, 0, 10));
    tbl.push_back(mk(0, 0, 1, 0, 6, 99, 0,  0, 0, 1, 2, 0, 0, 10));
    tbl.push_back(mk(0, 0, 1, 0, 5, 98, 0,  0, 0, 1, 2, 0, 0, 10));
    tbl.push_back(mk(0, 0, 0, 0, 5,  0, 0,  0, 1, 1, 2, 0, 0, 10));
    tbl.push_back(mk(0, 0, 0, 0, 5,  0, 1,  0, 1, 1, 1, 0, 0, 11));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  1, 0, 1, 1, 0, 0, 11));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  1, 0, 1, 1, 0, 0, 11));
    tbl.push_back(mk(0, 1, 1, 1, 5, 12, 0,  1, 0, 1, 2, 0, 0, 11));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  0, 0, 1, 2, 0, 0, 11));
    tbl.push_back(mk(1, 1, 0, 0, 5,  0, 0,  0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5,  0, 0,  1, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("tbl[%0d]", i);
      drive(tbl[i].rst, tbl[i].lu, tbl[i].fv, mk_flit(tbl[i].op, tbl[i].tg, tbl[i].tx), tbl[i].pop);
      @(posedge clock); #1;
      chk({tag, " lcrdv"}, rxreqlcrdv, tbl[i].e_lcrdv);
      chk({tag, " idle"}, link_idle, tbl[i].e_idle);
      chk({tag, " head_v"}, pocq_head_v, tbl[i].e_hv);
      chk({tag, " count"}, pocq_count, tbl[i].e_cnt);
      chk({tag, " err_tgtid"}, err_tgtid, tbl[i].e_et);
      chk({tag, " err_crd"}, err_crd, tbl[i].e_ec);
      if (tbl[i].e_hv) chk({tag, " head txnid"}, pocq_head.txnid, tbl[i].e_tx);
    end

    // Scripted corners: flit before any credit, enqueue+pop on empty queue,
    // enqueue+pop on a non-empty queue, and DRAIN falling back to RUN.
    drive(1, 0, 0, mk_flit(1, HN, 0), 0);  step_model("seq rst");
    drive(0, 1, 0, mk_flit(1, HN, 0), 0);  step_model("seq up");
    drive(0, 1, 1, mk_flit(1, HN, 20), 0); step_model("seq nocrd");
    drive(0, 1, 0, mk_flit(1, HN, 0), 0);  step_model("seq crd");
    drive(0, 1, 0, mk_flit(1, HN, 0), 0);  step_model("seq crd");
    drive(0, 1, 1, mk_flit(2, HN, 21), 1); step_model("seq enq+pop empty");
    drive(0, 1, 1, mk_flit(3, HN, 22), 1); step_model("seq enq+pop");
    drive(0, 0, 0, mk_flit(1, HN, 0), 0);  step_model("seq drain");
    drive(0, 1, 0, mk_flit(1, HN, 0), 0);  step_model("seq rerun");
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, mk_flit(1, HN, 0), 1); step_model("seq tail");
    end

    // Randomized run against the model.
    begin
      bit lu;
      lu = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        reqflit_t f;
        int op, tg;
        if ($urandom_range(0, 39) == 0) lu = ~lu;
        op = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 63));
        tg = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'(HN);
        f = mk_flit(op, tg, int'($urandom_range(0, 255)));
        f.addr = {$urandom(), $urandom()};
        drive($urandom_range(0, 299) == 0, lu, $urandom_range(0, 9) < 4, f,
              $urandom_range(0, 9) < 4);
        step_model("rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
